stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Command sequencer that sits between the command sources and the core_time counter datapath.
- Command sources: the board "go" button and the terminal's 11-bit op_code.
- Turns level inputs into single accepted commands, runs an explicit IDLE/RUN/PAUSE/LAP state machine, and drives core_time's run enable and clear.
- Owns split (lap) capture registers and a registered display mux: the terminal shows either live time or a frozen lap split.

Parameters:
- TW, 10, width of each time field (minutes, seconds, hundredths).
- LAPW, 4, width of lap counter.
- OP_START_STOP, 11'b00001000000, op_code for start/stop toggle.
- OP_LAP, 11'b00010000000, op_code for lap/split capture.
- OP_CLEAR, 11'b00100000000, op_code for clear to zero.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- go  in  1  button level, already synchronised to clk.
- op_code  in  11  terminal command, held as a level.
- live_minutes  in  TW  from core_time.
- live_seconds  in  TW  from core_time.
- live_hundreth  in  TW  from core_time.
- run_en  out  1  core_time count enable.
- clear_time  out  1  one-cycle pulse that zeroes core_time.
- disp_minutes  out  TW  display value.
- disp_seconds  out  TW  display value.
- disp_hundreth  out  TW  display value.
- lap_count  out  LAPW  number of laps taken since last clear.
- frozen  out  1  high while display shows the lap registers.
- state  out  2  encoded FSM state, for debug.

Behaviour:
- Reset (synchronous, active-high, one clock, reset port named "reset"): all outputs take their reset values on the next clk edge; reset overrides any command in the same cycle.
  - state = IDLE, run_en = 0, clear_time = 0, frozen = 0, lap_count = 0.
  - Lap registers = 0, disp_* = 0.
  - Edge-detect history registers = 0.
- Command acceptance: a command is accepted only on the first cycle its condition becomes true.
  - go: accepted on its 0->1 transition; counts as START_STOP.
  - op_code: accepted on the first cycle op_code equals an OP_* value after a cycle where it did not. Holding op_code issues exactly one command.
  - Unrecognised op_code values are ignored.
- Priority when several commands land in one cycle: CLEAR > START_STOP > LAP. A go edge and an OP_START_STOP edge in the same cycle form one toggle, not two.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- IDLE:
  - run_en = 0.
  - START_STOP -> RUN.
  - CLEAR -> clear_time pulse, stay IDLE.
  - LAP ignored.
- RUN:
  - run_en = 1.
  - START_STOP -> PAUSE.
  - LAP -> capture live_* into lap registers, lap_count += 1, go to LAP.
  - CLEAR -> clear_time pulse, zero lap registers and lap_count, go to IDLE.
- LAP (running, display frozen):
  - run_en = 1, frozen = 1.
  - LAP -> recapture and increment, stay LAP.
  - START_STOP -> PAUSE with frozen = 0.
  - CLEAR -> same as in RUN.
- PAUSE:
  - run_en = 0.
  - START_STOP -> RUN.
  - CLEAR -> same as in RUN.
  - LAP ignored.
- Output timing:
  - run_en and frozen are registered from the next state, so they change on the same edge as the state.
  - clear_time is high for exactly one cycle, on the edge where CLEAR is accepted.
  - Capture samples live_* in the cycle the LAP command is accepted.
- Display mux:
  - disp_* is registered with 1-cycle latency.
  - Source is the lap registers when frozen, else live_*.
  - On the clear cycle, disp_* loads 0 directly rather than the stale live value.
- lap_count saturates at 2^LAPW-1; further laps still recapture but do not wrap.
- No arithmetic on the time fields; they pass through unmodified at width TW.

Decomposition:
- stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, LAP) and its 2-bit encoding;
  - the OP_* localparam defaults;
  - the TW and LAPW defaults.
- One natural sub-module: cmd_edge.
  - One instance per command source.
  - Registers the previous match and emits a single-cycle accept pulse.
  - Four instances: go, start/stop, lap, clear. The go and start/stop pulses are ORed.
- The FSM, lap registers and display mux stay in stopwatch_ctrl.

Test Plan:
- Reset then idle 10 cycles -> run_en=0, state=0, disp_*=0, lap_count=0; hold op_code=OP_LAP -> no change.
- go high for 20 cycles starting at cycle 5 -> run_en rises at cycle 6 and stays 1 (single toggle). go low then high again -> run_en=0, state=PAUSE.
- In RUN with live = 1/23/45, pulse OP_LAP -> next cycle state=LAP, frozen=1, lap_count=1. disp_* holds 1/23/45 while live advances to 1/24/00; run_en stays 1.
- go edge and OP_START_STOP edge in the same cycle from RUN -> exactly one toggle to PAUSE.
- OP_CLEAR and a go edge in the same cycle from LAP -> clear_time high for exactly one cycle, state=IDLE, run_en=0, lap_count=0, disp_*=0.
- Take 17 laps -> lap_count=15 and the last split is captured. Assert reset mid-RUN -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch command sequencer.
package stopwatch_pkg;

  localparam int unsigned TW_DEF   = 10;
  localparam int unsigned LAPW_DEF = 4;

  localparam logic [10:0] OP_START_STOP_DEF = 11'b00001000000;
  localparam logic [10:0] OP_LAP_DEF        = 11'b00010000000;
  localparam logic [10:0] OP_CLEAR_DEF      = 11'b00100000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_cmd_edge.sv
// Rising-edge detector: one accept pulse on the first cycle a match condition holds.
module cmd_edge (
  input  logic clk,
  input  logic reset,
  input  logic match,
  output logic accept
);

  logic match_q;
  logic match_d;

  // Next history value is simply the current match level.
  always_comb begin
    match_d = match;
  end

  // History register for the match condition.
  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign accept = match & ~match_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: edge-accepted commands drive an IDLE/RUN/PAUSE/LAP
// FSM, core_time run/clear controls, lap split capture and a registered display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TW            = TW_DEF,
  parameter int unsigned LAPW          = LAPW_DEF,
  parameter logic [10:0] OP_START_STOP = OP_START_STOP_DEF,
  parameter logic [10:0] OP_LAP        = OP_LAP_DEF,
  parameter logic [10:0] OP_CLEAR      = OP_CLEAR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [10:0]     op_code,
  input  logic [TW-1:0]   live_minutes,
  input  logic [TW-1:0]   live_seconds,
  input  logic [TW-1:0]   live_hundreth,
  output logic            run_en,
  output logic            clear_time,
  output logic [TW-1:0]   disp_minutes,
  output logic [TW-1:0]   disp_seconds,
  output logic [TW-1:0]   disp_hundreth,
  output logic [LAPW-1:0] lap_count,
  output logic            frozen,
  output logic [1:0]      state
);

  logic go_acc, ss_acc, lap_acc, clr_acc;
  logic cmd_ss, cmd_lap, cmd_clr;

  cmd_edge u_edge_go (
    .clk(clk), .reset(reset), .match(go), .accept(go_acc)
  );
  cmd_edge u_edge_ss (
    .clk(clk), .reset(reset), .match(op_code == OP_START_STOP), .accept(ss_acc)
  );
  cmd_edge u_edge_lap (
    .clk(clk), .reset(reset), .match(op_code == OP_LAP), .accept(lap_acc)
  );
  cmd_edge u_edge_clr (
    .clk(clk), .reset(reset), .match(op_code == OP_CLEAR), .accept(clr_acc)
  );

  // Both start/stop sources merge into a single toggle.
  assign cmd_clr = clr_acc;
  assign cmd_ss  = go_acc | ss_acc;
  assign cmd_lap = lap_acc;

  state_t          state_q, state_d;
  logic            run_en_q, run_en_d;
  logic            frozen_q, frozen_d;
  logic            clear_q, clear_d;
  logic [TW-1:0]   lap_min_q, lap_min_d;
  logic [TW-1:0]   lap_sec_q, lap_sec_d;
  logic [TW-1:0]   lap_hun_q, lap_hun_d;
  logic [LAPW-1:0] lap_count_q, lap_count_d;
  logic [TW-1:0]   disp_min_q, disp_min_d;
  logic [TW-1:0]   disp_sec_q, disp_sec_d;
  logic [TW-1:0]   disp_hun_q, disp_hun_d;

  // Next-state, lap capture and display source selection; CLEAR > START_STOP > LAP.
  always_comb begin
    state_d     = state_q;
    clear_d     = 1'b0;
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_hun_d   = lap_hun_q;
    lap_count_d = lap_count_q;

    if (cmd_clr) begin
      clear_d     = 1'b1;
      state_d     = ST_IDLE;
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_hun_d   = '0;
      lap_count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_ss) state_d = ST_RUN;
        end
        ST_RUN, ST_LAP: begin
          if (cmd_ss) begin
            state_d = ST_PAUSE;
          end else if (cmd_lap) begin
            state_d     = ST_LAP;
            lap_min_d   = live_minutes;
            lap_sec_d   = live_seconds;
            lap_hun_d   = live_hundreth;
            lap_count_d = (lap_count_q == '1) ? lap_count_q : lap_count_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (cmd_ss) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    run_en_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    frozen_d = (state_d == ST_LAP);

    // Mux keys off next-state values so the display switches on the same edge as frozen.
    if (clear_d) begin
      disp_min_d = '0;
      disp_sec_d = '0;
      disp_hun_d = '0;
    end else if (frozen_d) begin
      disp_min_d = lap_min_d;
      disp_sec_d = lap_sec_d;
      disp_hun_d = lap_hun_d;
    end else begin
      disp_min_d = live_minutes;
      disp_sec_d = live_seconds;
      disp_hun_d = live_hundreth;
    end
  end

  // State, control outputs, lap registers and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_en_q    <= 1'b0;
      frozen_q    <= 1'b0;
      clear_q     <= 1'b0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_hun_q   <= '0;
      lap_count_q <= '0;
      disp_min_q  <= '0;
      disp_sec_q  <= '0;
      disp_hun_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= run_en_d;
      frozen_q    <= frozen_d;
      clear_q     <= clear_d;
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_hun_q   <= lap_hun_d;
      lap_count_q <= lap_count_d;
      disp_min_q  <= disp_min_d;
      disp_sec_q  <= disp_sec_d;
      disp_hun_q  <= disp_hun_d;
    end
  end

  assign state         = state_q;
  assign run_en        = run_en_q;
  assign frozen        = frozen_q;
  assign clear_time    = clear_q;
  assign lap_count     = lap_count_q;
  assign disp_minutes  = disp_min_q;
  assign disp_seconds  = disp_sec_q;
  assign disp_hundreth = disp_hun_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with hand-computed expectations.
module tb_stopwatch_ctrl;

  localparam int unsigned TW   = 10;
  localparam int unsigned LAPW = 4;
  localparam logic [10:0] OP_SS  = 11'b00001000000;
  localparam logic [10:0] OP_LP  = 11'b00010000000;
  localparam logic [10:0] OP_CL  = 11'b00100000000;

  logic            clk = 1'b0;
  logic            reset;
  logic            go;
  logic [10:0]     op_code;
  logic [TW-1:0]   live_minutes, live_seconds, live_hundreth;
  logic            run_en, clear_time, frozen;
  logic [TW-1:0]   disp_minutes, disp_seconds, disp_hundreth;
  logic [LAPW-1:0] lap_count;
  logic [1:0]      state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  stopwatch_ctrl #(.TW(TW), .LAPW(LAPW)) dut (
    .clk(clk), .reset(reset), .go(go), .op_code(op_code),
    .live_minutes(live_minutes), .live_seconds(live_seconds), .live_hundreth(live_hundreth),
    .run_en(run_en), .clear_time(clear_time),
    .disp_minutes(disp_minutes), .disp_seconds(disp_seconds), .disp_hundreth(disp_hundreth),
    .lap_count(lap_count), .frozen(frozen), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_disp(input string tag, input int unsigned m, input int unsigned s,
                            input int unsigned h);
    check({tag, "_min"}, disp_minutes, m);
    check({tag, "_sec"}, disp_seconds, s);
    check({tag, "_hun"}, disp_hundreth, h);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_run_en"}, run_en, 0);
    check({tag, "_clear"}, clear_time, 0);
    check({tag, "_frozen"}, frozen, 0);
    check({tag, "_lapcnt"}, lap_count, 0);
    check_disp(tag, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; op_code = '0;
    live_minutes = '0; live_seconds = '0; live_hundreth = '0;
    tick(2);
    reset = 1'b0;
    check_reset_vals("rst");
    tick(10);
    check_reset_vals("idle10");

    // LAP ignored in IDLE.
    op_code = OP_LP;
    tick(3);
    check("idle_lap_state", state, 0);
    check("idle_lap_cnt", lap_count, 0);
    check("idle_lap_frozen", frozen, 0);
    op_code = '0;
    tick();

    // Held go gives a single toggle.
    go = 1'b1;
    tick();
    check("go_run_en", run_en, 1);
    check("go_state", state, 1);
    tick(19);
    check("go_held_run_en", run_en, 1);
    check("go_held_state", state, 1);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    check("go2_state", state, 2);
    check("go2_run_en", run_en, 0);
    go = 1'b0;
    tick();

    // Resume, ignore unknown opcode, then take a lap.
    go = 1'b1;
    tick();
    check("resume_state", state, 1);
    go = 1'b0;
    op_code = 11'b00000000001;
    tick(2);
    check("unknown_op_state", state, 1);
    live_minutes = 1; live_seconds = 23; live_hundreth = 45;
    op_code = OP_LP;
    tick();
    check("lap1_state", state, 3);
    check("lap1_frozen", frozen, 1);
    check("lap1_cnt", lap_count, 1);
    live_minutes = 1; live_seconds = 24; live_hundreth = 0;
    tick();
    check_disp("lap1_hold", 1, 23, 45);
    check("lap1_run_en", run_en, 1);
    check("lap1_held_cnt", lap_count, 1);
    op_code = '0;
    tick();

    // Back to RUN, then simultaneous go + OP_START_STOP from RUN.
    go = 1'b1;
    tick();
    check("lap_to_pause_state", state, 2);
    check("lap_to_pause_frozen", frozen, 0);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    check("rerun_state", state, 1);
    go = 1'b0;
    tick();
    go = 1'b1; op_code = OP_SS;
    tick();
    check("dual_ss_state", state, 2);
    check("dual_ss_run_en", run_en, 0);
    tick();
    check("dual_ss_hold_state", state, 2);
    check_disp("pause_live", 1, 24, 0);
    go = 1'b0; op_code = '0;
    tick();

    // RUN -> LAP, then CLEAR with a go edge in the same cycle.
    go = 1'b1;
    tick();
    go = 1'b0; op_code = OP_LP;
    tick();
    check("lap2_state", state, 3);
    check("lap2_cnt", lap_count, 2);
    op_code = '0;
    tick();
    op_code = OP_CL; go = 1'b1;
    tick();
    check("clr_pulse", clear_time, 1);
    check("clr_state", state, 0);
    check("clr_run_en", run_en, 0);
    check("clr_cnt", lap_count, 0);
    check("clr_frozen", frozen, 0);
    check_disp("clr", 0, 0, 0);
    tick();
    check("clr_pulse_end", clear_time, 0);
    check("clr_hold_state", state, 0);
    op_code = '0; go = 1'b0;
    tick();

    // 17 laps: count saturates at 15, last split still captured.
    go = 1'b1;
    tick();
    check("sat_run_state", state, 1);
    go = 1'b0;
    for (int unsigned i = 1; i <= 17; i++) begin
      live_minutes = TW'(i); live_seconds = TW'(i + 2); live_hundreth = TW'(i + 5);
      op_code = OP_LP;
      tick();
      check($sformatf("lapn%0d_cnt", i), lap_count, (i > 15) ? 15 : i);
      op_code = '0;
      live_minutes = 50; live_seconds = 51; live_hundreth = 52;
      tick();
    end
    check("sat_state", state, 3);
    check_disp("sat_last", 17, 19, 22);

    // Reset mid-run overrides a simultaneous go edge.
    reset = 1'b1; go = 1'b1;
    tick();
    check_reset_vals("midrst");
    // Edge history was cleared, so the still-high go is taken as a fresh edge.
    reset = 1'b0;
    tick();
    check("post_rst_go_state", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
